// File: rtl/alu_share_arbiter_if.sv
// Bus bundle between the ALU share arbiter, its two requesters, the ALU and
// the response consumer. The slave modport is the arbiter's view; the master
// modport is the surrounding environment's view.
interface alu_share_arbiter_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned OP_W   = 4
);
  // Requester 0 (main pipeline)
  logic              req0_valid;
  logic              req0_ready;
  logic [OP_W-1:0]   req0_op;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;
  logic [1:0]        req0_cmp;
  // Requester 1 (branch/address unit)
  logic              req1_valid;
  logic              req1_ready;
  logic [OP_W-1:0]   req1_op;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;
  logic [1:0]        req1_cmp;
  // Shared ALU
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [OP_W-1:0]   alu_op;
  logic [1:0]        alu_cmp;
  logic [DATA_W-1:0] alu_result;
  logic              alu_zero;
  // Response
  logic              rsp_valid;
  logic              rsp_ready;
  logic              rsp_id;
  logic [DATA_W-1:0] rsp_result;
  logic              rsp_zero;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b, req0_cmp,
    input  req1_valid, req1_op, req1_a, req1_b, req1_cmp,
    input  alu_result, alu_zero, rsp_ready,
    output req0_ready, req1_ready,
    output alu_a, alu_b, alu_op, alu_cmp,
    output rsp_valid, rsp_id, rsp_result, rsp_zero
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b, req0_cmp,
    output req1_valid, req1_op, req1_a, req1_b, req1_cmp,
    output alu_result, alu_zero, rsp_ready,
    input  req0_ready, req1_ready,
    input  alu_a, alu_b, alu_op, alu_cmp,
    input  rsp_valid, rsp_id, rsp_result, rsp_zero
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin share of one combinational ALU between two requesters.
// Operands are captured on accept and drive the ALU from registers for one
// EXEC cycle; the ALU outputs are registered and returned on a valid/ready
// response tagged with the requester id.
module alu_share_arbiter #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned OP_W   = 4
) (
  input logic                clk,
  input logic                rst_n,
  alu_share_arbiter_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [1:0]        cmp_q, cmp_d;
  logic              id_q, id_d;
  logic              rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0] rsp_result_q, rsp_result_d;
  logic              rsp_zero_q, rsp_zero_d;

  logic any_valid;
  logic grant_id;
  logic window;
  logic accept;

  // Arbitration: a tie goes to the requester that did not win last time.
  always_comb begin
    any_valid = bus.req0_valid | bus.req1_valid;
    if (bus.req0_valid && bus.req1_valid) begin
      grant_id = ~last_grant_q;
    end else begin
      grant_id = ~bus.req0_valid;
    end
    window = (state_q == IDLE) | ((state_q == RESP) & bus.rsp_ready);
    accept = window & any_valid;
  end

  assign bus.req0_ready = accept & ~grant_id;
  assign bus.req1_ready = accept & grant_id;

  // Next-state, operand capture and result capture.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    op_d         = op_q;
    a_d          = a_q;
    b_d          = b_q;
    cmp_d        = cmp_q;
    id_d         = id_q;
    rsp_id_d     = rsp_id_q;
    rsp_result_d = rsp_result_q;
    rsp_zero_d   = rsp_zero_q;

    case (state_q)
      IDLE: if (accept) state_d = EXEC;
      EXEC: state_d = RESP;
      RESP: begin
        if (bus.rsp_ready) state_d = accept ? EXEC : IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (accept) begin
      last_grant_d = grant_id;
      id_d         = grant_id;
      op_d         = grant_id ? bus.req1_op  : bus.req0_op;
      a_d          = grant_id ? bus.req1_a   : bus.req0_a;
      b_d          = grant_id ? bus.req1_b   : bus.req0_b;
      cmp_d        = grant_id ? bus.req1_cmp : bus.req0_cmp;
    end

    // ALU outputs are sampled only at the end of the EXEC cycle.
    if (state_q == EXEC) begin
      rsp_id_d     = id_q;
      rsp_result_d = bus.alu_result;
      rsp_zero_d   = bus.alu_zero;
    end
  end

  // State registers; last_grant resets to 1 so req0 wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      op_q         <= '0;
      a_q          <= '0;
      b_q          <= '0;
      cmp_q        <= '0;
      id_q         <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_result_q <= '0;
      rsp_zero_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      op_q         <= op_d;
      a_q          <= a_d;
      b_q          <= b_d;
      cmp_q        <= cmp_d;
      id_q         <= id_d;
      rsp_id_q     <= rsp_id_d;
      rsp_result_q <= rsp_result_d;
      rsp_zero_q   <= rsp_zero_d;
    end
  end

  assign bus.alu_a      = a_q;
  assign bus.alu_b      = b_q;
  assign bus.alu_op     = op_q;
  assign bus.alu_cmp    = cmp_q;
  assign bus.rsp_valid  = (state_q == RESP);
  assign bus.rsp_id     = rsp_id_q;
  assign bus.rsp_result = rsp_result_q;
  assign bus.rsp_zero   = rsp_zero_q;

endmodule
